// File: rtl/count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// count_seq_ctrl
// Stopwatch / interval-timer sequencer for a 9-bit counter.
// Turns start/stop/lap command pulses into counter enable and clear pulses.
// A prescaler paces the count advances.
// The run halts when the counter feedback reaches LIMIT.
// Lap commands capture a snapshot of the fed-back count.
// All outputs are registered, so a command acts on the edge after it is seen.
// ---------------------------------------------------------------------------
module count_seq_ctrl #(
   parameter logic [8:0] LIMIT    = 9'd15,
   parameter int         PRESCALE = 4
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       start,
   input  logic       stop,
   input  logic       lap,
   input  logic [8:0] cin,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic [8:0] lap_val,
   output logic       lap_valid,
   output logic       running,
   output logic       done
);

   // Last prescaler phase. An advance is due when the prescaler sits here.
   localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t     state_r;
   logic [7:0] prescale_r;
   logic       lap_ok_s;
   logic       at_limit_s;

   // Lap snapshots are honoured only once a run has really started.
   // The limit compare is shared by the sequencing logic.
   always_comb begin
      lap_ok_s   = 1'b0;
      at_limit_s = 1'b0;
      if ((state_r == RUN) || (state_r == PAUSE) || (state_r == DONE)) begin
         lap_ok_s = 1'b1;
      end else begin
         lap_ok_s = 1'b0;
      end
      if (cin == LIMIT) begin
         at_limit_s = 1'b1;
      end else begin
         at_limit_s = 1'b0;
      end
   end

   // Sequencer: state, prescaler and all registered outputs.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_r    <= IDLE;
         prescale_r <= 8'd0;
         cnt_en     <= 1'b0;
         cnt_clr    <= 1'b0;
         lap_val    <= 9'd0;
         lap_valid  <= 1'b0;
         running    <= 1'b0;
         done       <= 1'b0;
      end else begin
         // Pulse outputs default low and are raised only by the cycle's decision.
         cnt_en    <= 1'b0;
         cnt_clr   <= 1'b0;
         lap_valid <= 1'b0;

         case (state_r)
            IDLE: begin
               // stop and lap have no meaning before a run exists.
               if (start) begin
                  state_r <= CLR;
                  cnt_clr <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end

            CLR: begin
               // The counter clears on this edge, so the first RUN cycle sees cin == 0.
               prescale_r <= 8'd0;
               state_r    <= RUN;
               running    <= 1'b1;
            end

            RUN: begin
               if (at_limit_s) begin
                  // Reaching the terminal count outranks a stop in the same cycle.
                  state_r <= DONE;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (stop) begin
                  // The prescaler is frozen, so the partial tick period resumes later.
                  state_r <= PAUSE;
                  running <= 1'b0;
               end else if (prescale_r == PS_LAST) begin
                  prescale_r <= 8'd0;
                  cnt_en     <= 1'b1;
               end else begin
                  prescale_r <= prescale_r + 8'd1;
               end
            end

            PAUSE: begin
               // stop outranks start: a simultaneous pair aborts the run.
               if (stop) begin
                  state_r <= IDLE;
               end else if (start) begin
                  state_r <= RUN;
                  running <= 1'b1;
               end else begin
                  state_r <= PAUSE;
               end
            end

            DONE: begin
               if (stop) begin
                  state_r <= IDLE;
                  done    <= 1'b0;
               end else if (start) begin
                  state_r <= CLR;
                  cnt_clr <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  state_r <= DONE;
               end
            end

            default: begin
               state_r    <= IDLE;
               prescale_r <= 8'd0;
               running    <= 1'b0;
               done       <= 1'b0;
            end
         endcase

         // Lap works alongside any transition.
         // It captures cin as seen in the command cycle.
         if (lap && lap_ok_s) begin
            lap_val   <= cin;
            lap_valid <= 1'b1;
         end else begin
            lap_val   <= lap_val;
         end
      end
   end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_seq_ctrl
// Two controllers share one command stream.
// One instance uses LIMIT=15 and the other uses LIMIT=0; both use PRESCALE=4.
// Each instance drives its own behavioural 9-bit counter that feeds cin.
// A reference model predicts every output from the command rules,
// using run flags and a count of paced cycles.
// ---------------------------------------------------------------------------
module tb_count_seq_ctrl;

   localparam int         PRE  = 4;
   localparam logic [8:0] LIM0 = 9'd15;
   localparam logic [8:0] LIM1 = 9'd0;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       lap = 1'b0;
   logic [8:0] cnt0;
   logic [8:0] cnt1;
   wire  [1:0] en;
   wire  [1:0] clr;
   wire  [1:0] lv;
   wire  [1:0] rn;
   wire  [1:0] dn;
   wire  [8:0] lval0;
   wire  [8:0] lval1;

   int nvec = 0;
   int nerr = 0;

   // model state
   logic [1:0] e_en = 2'b00, e_clr = 2'b00, e_lv = 2'b00;
   logic [1:0] pend_en = 2'b00, pend_clr = 2'b00;
   logic [1:0] m_run = 2'b00, m_clrg = 2'b00, m_paus = 2'b00, m_fin = 2'b00;
   int         m_work [2];
   logic [8:0] m_cnt [2];
   logic [8:0] m_lap [2];

   always #5 clk = ~clk;

   count_seq_ctrl #(.LIMIT(LIM0), .PRESCALE(PRE)) dut (
      .clk(clk), .clear(clear), .start(start), .stop(stop), .lap(lap), .cin(cnt0),
      .cnt_en(en[0]), .cnt_clr(clr[0]), .lap_val(lval0), .lap_valid(lv[0]),
      .running(rn[0]), .done(dn[0]));

   count_seq_ctrl #(.LIMIT(LIM1), .PRESCALE(PRE)) dut0 (
      .clk(clk), .clear(clear), .start(start), .stop(stop), .lap(lap), .cin(cnt1),
      .cnt_en(en[1]), .cnt_clr(clr[1]), .lap_val(lval1), .lap_valid(lv[1]),
      .running(rn[1]), .done(dn[1]));

   // External counters driven by each controller.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) cnt0 <= 9'd0;
      else if (clr[0]) cnt0 <= 9'd0;
      else if (en[0]) cnt0 <= cnt0 + 9'd1;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) cnt1 <= 9'd0;
      else if (clr[1]) cnt1 <= 9'd0;
      else if (en[1]) cnt1 <= cnt1 + 9'd1;
   end

   function automatic logic [8:0] cin_of(input int i);
      return (i == 0) ? cnt0 : cnt1;
   endfunction

   function automatic logic [8:0] lval_of(input int i);
      return (i == 0) ? lval0 : lval1;
   endfunction

   function automatic logic [8:0] lim_of(input int i);
      return (i == 0) ? LIM0 : LIM1;
   endfunction

   task automatic chk(input string tag, input int i, input logic [8:0] obs, input logic [8:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s[%0d]: observed %0d expected %0d", tag, i, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_en = 2'b00; e_clr = 2'b00; e_lv = 2'b00;
      pend_en = 2'b00; pend_clr = 2'b00;
      m_run = 2'b00; m_clrg = 2'b00; m_paus = 2'b00; m_fin = 2'b00;
      for (int i = 0; i < 2; i++) begin
         m_work[i] = 0;
         m_cnt[i]  = 9'd0;
         m_lap[i]  = 9'd0;
      end
   endtask

   // Predict the outputs that follow the coming clock edge.
   task automatic model_step(input logic st, input logic sp, input logic lp);
      for (int i = 0; i < 2; i++) begin
         // The counter acts on the pulse shown one cycle earlier.
         if (pend_clr[i]) m_cnt[i] = 9'd0;
         else if (pend_en[i]) m_cnt[i] = m_cnt[i] + 9'd1;
         pend_clr[i] = e_clr[i];
         pend_en[i]  = e_en[i];
         chk("cin", i, cin_of(i), m_cnt[i]);

         e_en[i] = 1'b0; e_clr[i] = 1'b0; e_lv[i] = 1'b0;
         if (lp && (m_run[i] || m_paus[i] || m_fin[i])) begin
            e_lv[i]  = 1'b1;
            m_lap[i] = m_cnt[i];
         end
         if (m_clrg[i]) begin
            m_clrg[i] = 1'b0; m_run[i] = 1'b1; m_work[i] = 0;
         end else if (m_run[i]) begin
            if (m_cnt[i] == lim_of(i)) begin
               m_run[i] = 1'b0; m_fin[i] = 1'b1;
            end else if (sp) begin
               m_run[i] = 1'b0; m_paus[i] = 1'b1;
            end else begin
               if ((m_work[i] % PRE) == PRE - 1) e_en[i] = 1'b1;
               m_work[i]++;
            end
         end else if (m_paus[i]) begin
            if (sp) m_paus[i] = 1'b0;
            else if (st) begin m_paus[i] = 1'b0; m_run[i] = 1'b1; end
         end else if (m_fin[i]) begin
            if (sp) m_fin[i] = 1'b0;
            else if (st) begin m_fin[i] = 1'b0; m_clrg[i] = 1'b1; e_clr[i] = 1'b1; end
         end else if (st) begin
            m_clrg[i] = 1'b1; e_clr[i] = 1'b1;
         end
      end
   endtask

   task automatic step(input logic st, input logic sp, input logic lp);
      @(negedge clk);
      start = st; stop = sp; lap = lp;
      model_step(st, sp, lp);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("cnt_en",    i, {8'd0, en[i]},  {8'd0, e_en[i]});
         chk("cnt_clr",   i, {8'd0, clr[i]}, {8'd0, e_clr[i]});
         chk("lap_valid", i, {8'd0, lv[i]},  {8'd0, e_lv[i]});
         chk("running",   i, {8'd0, rn[i]},  {8'd0, m_run[i]});
         chk("done",      i, {8'd0, dn[i]},  {8'd0, m_fin[i]});
         chk("lap_val",   i, lval_of(i),     m_lap[i]);
      end
   endtask

   // Pulse clear between edges and check that the outputs drop asynchronously.
   task automatic do_reset();
      @(posedge clk);
      #3;
      start = 1'b0; stop = 1'b0; lap = 1'b0;
      clear = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         chk("rst_cnt_en",    i, {8'd0, en[i]},  9'd0);
         chk("rst_cnt_clr",   i, {8'd0, clr[i]}, 9'd0);
         chk("rst_lap_valid", i, {8'd0, lv[i]},  9'd0);
         chk("rst_running",   i, {8'd0, rn[i]},  9'd0);
         chk("rst_done",      i, {8'd0, dn[i]},  9'd0);
         chk("rst_lap_val",   i, lval_of(i),     9'd0);
         chk("rst_cin",       i, cin_of(i),      9'd0);
      end
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();

      // A lap in IDLE is ignored.
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // Free run to the limit, with a lap taken at cin == 7.
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 80 && cnt0 != 9'd7; n++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("lap_at_7", 0, lval0, 9'd7);
      for (int n = 0; n < 120 && dn[0] !== 1'b1; n++) step(1'b0, 1'b0, 1'b0);
      chk("done_reached", 0, {8'd0, dn[0]}, 9'd1);
      chk("held_at_limit", 0, cnt0, LIM0);
      for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b0);

      // Restart from DONE; stop two cycles after an advance, pause, then resume.
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 20 && en[0] !== 1'b1; n++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 20; n++) step(1'b0, 1'b0, (n == 5) ? 1'b1 : 1'b0);
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 10; n++) step(1'b0, 1'b0, 1'b0);

      // start+stop in RUN pauses; start+stop in PAUSE returns to IDLE.
      step(1'b1, 1'b1, 1'b0);
      chk("pause_on_pair", 0, {8'd0, rn[0]}, 9'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      // A stop arriving when cin == LIMIT still ends in DONE.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 80 && cnt0 != LIM0; n++) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("limit_beats_stop", 0, {8'd0, dn[0]}, 9'd1);
      step(1'b0, 1'b1, 1'b0);

      // Clear in the middle of a run, then start again.
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 10; n++) step(1'b0, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 12; n++) step(1'b0, 1'b0, 1'b0);

      // Random command traffic.
      for (int n = 0; n < 500; n++) begin
         if (n == 250) do_reset();
         step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
